// File: rtl/weprom_rx_if.sv
// Serial link from a weprom sender into weprom_rx: data bit, bit clock and frame envelope.
interface weprom_rx_if;
    logic sda;
    logic sda_clk;
    logic out_vaild;

    modport master (output sda, output sda_clk, output out_vaild);
    modport slave  (input  sda, input  sda_clk, input  out_vaild);
endinterface

// File: rtl/weprom_rx.sv
// weprom link receiver: deserialises LSB-first address/data frames into a
// 2**ADDR_W x DATA_W array and flags short or over-long frames.
module weprom_rx #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    weprom_rx_if.slave        link,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              wr_done,
    output logic              frame_err,
    output logic              busy
);
    localparam int CNT_W = $clog2(ADDR_W + DATA_W) + 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR    = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] DONE    = 3'd3;
    localparam logic [2:0] WAITLOW = 3'd4;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_sr;
    logic [DATA_W-1:0] data_sr;
    logic              sda_clk_q;
    logic              bit_edge;
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_comb begin
        bit_edge  = link.sda_clk & ~sda_clk_q & link.out_vaild;
        busy      = (state != IDLE);
        wr_done   = (state == DONE) & ~rst;
        frame_err = ~rst & ((((state == ADDR) | (state == DATA)) & ~link.out_vaild) |
                            ((state == WAITLOW) & bit_edge));
        rd_data   = mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            sda_clk_q <= 1'b0;
            addr_o    <= '0;
            data_o    <= '0;
        end else begin
            sda_clk_q <= link.sda_clk;
            case (state)
                IDLE: begin
                    // An edge coinciding with the envelope rising is already address bit 0.
                    if (link.out_vaild) begin
                        state <= ADDR;
                        cnt   <= '0;
                        if (bit_edge) begin
                            addr_sr <= {link.sda, addr_sr[ADDR_W-1:1]};
                            cnt     <= CNT_W'(1);
                        end
                    end
                end
                ADDR: begin
                    if (!link.out_vaild) begin
                        state   <= IDLE;
                        addr_sr <= '0;
                        data_sr <= '0;
                    end else if (bit_edge) begin
                        addr_sr <= {link.sda, addr_sr[ADDR_W-1:1]};
                        if (cnt == ADDR_LAST) begin
                            state <= DATA;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (!link.out_vaild) begin
                        state   <= IDLE;
                        addr_sr <= '0;
                        data_sr <= '0;
                    end else if (bit_edge) begin
                        data_sr <= {link.sda, data_sr[DATA_W-1:1]};
                        if (cnt == DATA_LAST) begin
                            state <= DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    addr_o <= addr_sr;
                    data_o <= data_sr;
                    state  <= link.out_vaild ? WAITLOW : IDLE;
                end
                WAITLOW: begin
                    if (!link.out_vaild) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Target array has no reset; unwritten entries stay undefined.
    always_ff @(posedge clk) begin
        if (!rst && state == DONE) mem[addr_sr] <= data_sr;
    end
endmodule

// File: tb/tb_weprom_rx.sv
// Randomised self-checking bench for weprom_rx against an edge-counting frame model.
module tb_weprom_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rd_addr = '0;
    logic [7:0] rd_data, addr_o, data_o;
    logic       wr_done, frame_err, busy;
    bit         rd_hold = 1'b0;

    int checks = 0;
    int errors = 0;

    weprom_rx_if link ();

    weprom_rx #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .link      (link),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .addr_o    (addr_o),
        .data_o    (data_o),
        .wr_done   (wr_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is simply the ordered list of bit edges seen while the envelope is high.
    logic [7:0]  m_mem [256];
    bit          m_written [256];
    logic [7:0]  m_addr = '0, m_data = '0;
    logic [15:0] word = '0;
    int          nedges = 0;
    bit          done_pend = 0, busy_exp = 0, sclk_q = 0, model_ok = 0;
    int          wr_seen = 0, err_seen = 0;

    always @(negedge clk) begin
        bit edge_now, e_wr, e_err;
        edge_now = link.sda_clk && !sclk_q && link.out_vaild;
        e_wr     = done_pend && !rst;
        e_err    = !rst && busy_exp &&
                   ((nedges < 16 && !link.out_vaild) || (edge_now && nedges >= 16 && !done_pend));
        if (wr_done === 1'b1) wr_seen++;
        if (frame_err === 1'b1) err_seen++;
        if (model_ok) begin
            check("wr_done", 32'(wr_done), 32'(e_wr));
            check("frame_err", 32'(frame_err), 32'(e_err));
            check("busy", 32'(busy), 32'(busy_exp));
            check("addr_o", 32'(addr_o), 32'(m_addr));
            check("data_o", 32'(data_o), 32'(m_data));
            if (m_written[rd_addr]) check("rd_data", 32'(rd_data), 32'(m_mem[rd_addr]));
        end
        if (rst) begin
            nedges = 0; done_pend = 0; sclk_q = 0; busy_exp = 0;
            m_addr = '0; m_data = '0; model_ok = 1;
        end else begin
            if (e_wr) begin
                m_mem[word[7:0]]     = word[15:8];
                m_written[word[7:0]] = 1;
                m_addr = word[7:0];
                m_data = word[15:8];
            end
            if (!busy_exp) nedges = 0;
            done_pend = 0;
            if (edge_now) begin
                if (nedges < 16) word[nedges[3:0]] = link.sda;
                nedges++;
                done_pend = (nedges == 16);
            end
            sclk_q   = link.sda_clk;
            busy_exp = link.out_vaild;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        link.sda = 1'($urandom);
        if (!rd_hold) rd_addr = 8'($urandom);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            int h, l;
            h = $urandom_range(1, 2);
            l = $urandom_range(1, 3);
            tick();
            link.sda     = w[i];
            link.sda_clk = 1'b1;
            repeat (h - 1) tick();
            tick();
            link.sda_clk = 1'b0;
            repeat (l - 1) tick();
        end
    endtask

    task automatic start_frame();
        tick();
        link.out_vaild = 1'b1;
    endtask

    task automatic end_frame();
        repeat (2) tick();
        link.out_vaild = 1'b0;
        repeat (3) tick();
    endtask

    task automatic lit_rd(input string name, input logic [7:0] a, input logic [7:0] exp);
        rd_hold = 1'b1;
        rd_addr = a;
        @(negedge clk);
        check(name, 32'(rd_data), 32'(exp));
        tick();
        rd_hold = 1'b0;
    endtask

    initial begin
        int w0, e0;
        link.sda = 1'b0; link.sda_clk = 1'b0; link.out_vaild = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset addr_o", 32'(addr_o), 32'h0);
        check("reset data_o", 32'(data_o), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset wr_done", 32'(wr_done), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);

        // Good frame A5/B2
        w0 = wr_seen;
        start_frame(); send_bits(32'h0000B2A5, 16); end_frame();
        check("good wr count", 32'(wr_seen - w0), 32'd1);
        check("good addr_o", 32'(addr_o), 32'hA5);
        check("good data_o", 32'(data_o), 32'hB2);
        lit_rd("good rd A5", 8'hA5, 8'hB2);

        // Reset held 3 cycles in the middle of a frame
        w0 = wr_seen;
        start_frame(); send_bits(32'h0000007F, 7);
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("midrst addr_o", 32'(addr_o), 32'h0);
        check("midrst data_o", 32'(data_o), 32'h0);
        check("midrst busy", 32'(busy), 32'h0);
        link.out_vaild = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("midrst wr count", 32'(wr_seen - w0), 32'd0);

        // Back-to-back frames with overwrite of 0xA5
        w0 = wr_seen;
        start_frame(); send_bits(32'h0000F00F, 16); end_frame();
        start_frame(); send_bits(32'h000011A5, 16); end_frame();
        check("b2b wr count", 32'(wr_seen - w0), 32'd2);
        lit_rd("b2b rd 0F", 8'h0F, 8'hF0);
        lit_rd("b2b rd A5", 8'hA5, 8'h11);

        // Short frame: 5 address bits only
        w0 = wr_seen; e0 = err_seen;
        start_frame(); send_bits(32'h00000015, 5); end_frame();
        check("short err count", 32'(err_seen - e0), 32'd1);
        check("short wr count", 32'(wr_seen - w0), 32'd0);
        check("short addr_o", 32'(addr_o), 32'hA5);
        check("short data_o", 32'(data_o), 32'h11);

        // Long frame: 18 edges
        w0 = wr_seen; e0 = err_seen;
        start_frame(); send_bits(32'h00033D77, 18); end_frame();
        check("long wr count", 32'(wr_seen - w0), 32'd1);
        check("long err count", 32'(err_seen - e0), 32'd2);
        lit_rd("long rd 77", 8'h77, 8'h3D);

        // Reset after 10 bits with envelope kept high, then a full frame
        w0 = wr_seen;
        start_frame(); send_bits(32'h00000299, 10);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        send_bits(32'h00005A3C, 16); end_frame();
        check("rstframe wr count", 32'(wr_seen - w0), 32'd1);
        check("rstframe addr_o", 32'(addr_o), 32'h3C);
        lit_rd("rstframe rd 3C", 8'h3C, 8'h5A);

        // Randomised frames of good, short and long lengths
        for (int k = 0; k < 40; k++) begin
            int r, n;
            logic [7:0] a, d;
            r = $urandom_range(0, 9);
            n = (r < 6) ? 16 : (r < 8) ? $urandom_range(1, 15) : $urandom_range(17, 19);
            a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            d = 8'($urandom);
            start_frame();
            send_bits({8'($urandom), 8'($urandom), d, a}, n);
            end_frame();
        end

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/weprom_rx.md
# weprom_rx

Downstream receiver for the `weprom` serial link. It sits on `sda`/`sda_clk`/`out_vaild` and deserialises each frame into an 8-bit address and an 8-bit data byte. It writes the byte into an internal 256×8 array that models the EEPROM target, and it flags malformed frames. Bench and system code read the array back through a combinational read port.

## Interface
- `ADDR_W`, default 8: address bits per frame; array depth is 2**ADDR_W.
- `DATA_W`, default 8: data bits per frame.
- `clk` in 1: single system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sda` in 1: serial data, sampled on `sda_clk` rising edges.
- `sda_clk` in 1: serial bit clock, generated from `clk` upstream, so no synchroniser is needed.
- `out_vaild` in 1: frame envelope; high for the whole frame.
- `rd_addr` in ADDR_W: array read address.
- `rd_data` out DATA_W: combinational `mem[rd_addr]`.
- `addr_o` out ADDR_W: address of the last good frame.
- `data_o` out DATA_W: data of the last good frame.
- `wr_done` out 1: one-cycle pulse when the array write happens.
- `frame_err` out 1: one-cycle pulse when a malformed frame is detected.
- `busy` out 1: high while not in IDLE.

## Operation
- Edge detect: register `sda_clk_q` every cycle. A bit edge is `sda_clk & ~sda_clk_q & out_vaild`. The bit value is `sda` in the same cycle.
- Frame format: ADDR_W address bits, then DATA_W data bits. Each field is sent LSB first; bit 0 is the first bit shifted in.
- Shifting: each field register shifts right, with the new bit entering at the MSB. After the field's last bit, the field is in natural order.
- Bit counter: width clog2(ADDR_W+DATA_W)+1.
- FSM states: IDLE, ADDR, DATA, DONE, WAITLOW.
  - IDLE → ADDR when `out_vaild`=1. Clear the bit counter. If an edge occurs in that same cycle, it is bit 0.
  - ADDR: shift on each edge. After the ADDR_W-th bit → DATA.
  - DATA: shift on each edge. After the DATA_W-th bit → DONE.
  - DONE, one cycle only: write `mem[addr_sr] <= data_sr`, latch `addr_o`/`data_o`, pulse `wr_done`. Then → WAITLOW, or → IDLE if `out_vaild`=0.
  - WAITLOW: → IDLE when `out_vaild`=0. An edge while `out_vaild`=1 pulses `frame_err` once per extra edge. No second write occurs and the state does not change.
  - ADDR/DATA with `out_vaild`=0: the frame is short. Pulse `frame_err`, discard the shift registers, no write → IDLE.
- The array is not cleared by reset; unwritten entries read X.
- Reset mid-frame: FSM → IDLE and the partial frame is discarded. A frame whose `out_vaild` is still high after reset restarts counting from the next edge as bit 0.

## Timing
- Reset values: `addr_o`=0, `data_o`=0, `wr_done`=0, `frame_err`=0, `busy`=0, `sda_clk_q`=0, FSM=IDLE, counters=0.
- If the last data edge is detected in cycle N:
  - DONE occurs in N+1, with `wr_done`=1 in N+1.
  - `addr_o`/`data_o` update at the end of N+1.
  - `rd_data` at that address reflects the new value from N+2.
- Short-frame `frame_err` is asserted in the first cycle in which `out_vaild`=0 is seen in ADDR/DATA.
- An edge is never detected on consecutive cycles, because `sda_clk` has a minimum period of 2 `clk` cycles.
- `addr_o`/`data_o` hold their values until the next good frame. Error frames do not change them.
- `busy` is combinational from the state: 0 only in IDLE.

## Test plan
- Reset: assert `rst` 3 cycles mid-stream → all outputs 0, FSM IDLE, no `wr_done`.
- Good frame: address 0xA5 (bits 1,0,1,0,0,1,0,1), data 0xB2 (bits 0,1,0,0,1,1,0,1) → `wr_done` one cycle after the 16th edge, `addr_o`=0xA5, `data_o`=0xB2; `rd_addr`=0xA5 → `rd_data`=0xB2.
- Back-to-back frames: addr 0x0F/data 0xF0, then addr 0xA5/data 0x11 → two `wr_done` pulses; `mem[0x0F]`=0xF0, `mem[0xA5]`=0x11 (overwrite).
- Short frame: drop `out_vaild` after 5 address bits → `frame_err` one cycle, no `wr_done`, `addr_o`/`data_o` unchanged, `busy` 0 the next cycle.
- Long frame: send 18 edges → `wr_done` once after edge 16, `frame_err` pulses at edges 17 and 18, array holds the 16-bit frame only.
- Reset mid-frame: `rst` after 10 bits, then a full new frame with addr 0x3C/data 0x5A → only `mem[0x3C]`=0x5A is written, with one `wr_done`.
